// File: rtl/read_burst_planner_if.sv
// Burst descriptor handshake and completion channel between the read planner
// and the AXI read master.
interface read_burst_planner_if #(
  parameter int LSIZE = 9
);
  logic             req_valid;
  logic             req_ready;
  logic [LSIZE-1:0] req_len;
  logic             req_eol;
  logic             req_eof;
  logic             burst_done;

  modport master (
    output req_valid, req_len, req_eol, req_eof,
    input  req_ready, burst_done
  );

  modport slave (
    input  req_valid, req_len, req_eol, req_eof,
    output req_ready, burst_done
  );
endinterface

// File: rtl/read_burst_planner.sv
// VDMA read-side burst planner: turns frame geometry into full/tail burst
// descriptors, throttles outstanding bursts and reports frame completion.
module read_burst_planner #(
  parameter int NOR_BURST_LEN   = 200,
  parameter     MODE            = "ONCE",
  parameter int AXI_DSIZE       = 256,
  parameter int DSIZE           = 24,
  parameter int LSIZE           = 9,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [15:0] vactive,
  input  logic [15:0] hactive,
  input  logic        fsync,
  read_burst_planner_if.master req,
  output logic [3:0]  outstanding,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);

  localparam bit LINE_MODE = (MODE == "LINE");
  localparam int AXI_SHIFT = $clog2(AXI_DSIZE);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE, DRAIN} state_t;

  state_t      state;
  logic [1:0]  calc_cnt;
  logic [15:0] hact_s;
  logic [15:0] vact_s;
  logic [39:0] bits_p0;
  logic [31:0] beats_p1;
  logic [31:0] nfull_p2;
  logic [31:0] tail_p2;
  logic [31:0] burst_idx;
  logic [15:0] unit_idx;
  logic [31:0] bursts_per_unit;
  logic [15:0] units;
  logic        last_burst;
  logic        last_unit;
  logic        accept;

  // Round a bit count up to whole AXI beats.
  function automatic logic [31:0] ceil_beats(input logic [39:0] bits);
    logic [39:0] sum;
    sum = bits + 40'(AXI_DSIZE - 1);
    return 32'(sum >> AXI_SHIFT);
  endfunction

  // Outstanding counter step; a completion with nothing in flight saturates at zero.
  function automatic logic [3:0] next_outstanding(input logic [3:0] cur,
                                                  input logic inc,
                                                  input logic dec);
    logic [3:0] nxt;
    case ({inc, dec})
      2'b10:   nxt = cur + 4'd1;
      2'b01:   nxt = (cur == 4'd0) ? 4'd0 : cur - 4'd1;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  assign units           = LINE_MODE ? vact_s : 16'd1;
  assign bursts_per_unit = nfull_p2 + {31'd0, (tail_p2 != 32'd0)};
  assign last_burst      = (burst_idx == bursts_per_unit - 32'd1);
  assign last_unit       = (unit_idx == units - 16'd1);

  assign req.req_valid = (state == ISSUE) && (outstanding < 4'(MAX_OUTSTANDING));
  assign accept        = req.req_valid && req.req_ready;
  assign req.req_len   = (state != ISSUE) ? '0 :
                         (last_burst && tail_p2 != 32'd0) ? LSIZE'(tail_p2) :
                         LSIZE'(NOR_BURST_LEN);
  assign req.req_eol   = (state == ISSUE) && last_burst;
  assign req.req_eof   = req.req_eol && last_unit;
  assign busy          = (state != IDLE);

  // Geometry sample, then p0 multiply -> p1 ceil to beats -> p2 div/mod.
  // Free-running; the geometry only moves on fsync so results hold during ISSUE.
  always_ff @(posedge clock) begin
    if (fsync) begin
      hact_s <= hactive;
      vact_s <= vactive;
    end
    bits_p0  <= LINE_MODE ? 40'(hact_s) * 40'(DSIZE)
                          : 40'(hact_s) * 40'(vact_s) * 40'(DSIZE);
    beats_p1 <= ceil_beats(bits_p0);
    nfull_p2 <= beats_p1 / 32'(NOR_BURST_LEN);
    tail_p2  <= beats_p1 % 32'(NOR_BURST_LEN);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state       <= IDLE;
      calc_cnt    <= 2'd0;
      burst_idx   <= 32'd0;
      unit_idx    <= 16'd0;
      outstanding <= 4'd0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      outstanding <= next_outstanding(outstanding, accept, req.burst_done);

      if (fsync)
        err <= 1'b0;
      else if (req.burst_done && outstanding == 4'd0)
        err <= 1'b1;

      // fsync restarts from any state; in-flight bursts keep draining the counter.
      if (fsync) begin
        state     <= CALC;
        calc_cnt  <= 2'd0;
        burst_idx <= 32'd0;
        unit_idx  <= 16'd0;
      end else begin
        case (state)
          CALC: begin
            if (calc_cnt == 2'd2)
              state <= (beats_p1 == 32'd0 || units == 16'd0) ? DRAIN : ISSUE;
            else
              calc_cnt <= calc_cnt + 2'd1;
          end
          ISSUE: begin
            if (accept) begin
              if (last_burst) begin
                burst_idx <= 32'd0;
                if (last_unit)
                  state <= DRAIN;
                else
                  unit_idx <= unit_idx + 16'd1;
              end else begin
                burst_idx <= burst_idx + 32'd1;
              end
            end
          end
          DRAIN: begin
            if (outstanding == 4'd0) begin
              state      <= IDLE;
              frame_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
